phase_duration_timer: RTL and testbench
=======================================

// Module: phase_duration_timer
// PURPOSE
//  Programmable multi-slot phase timer for the traffic-light controller; supersedes fixed 25 s/4 s counters.
//  Holds NUM_SLOTS run-time-loadable durations in whole seconds; the FSM selects one with slot_sel and pulses start.
//  Adds pause/hold, abort, retrigger, zero-length phases, a one-cycle done pulse and a live seconds-remaining count for display.
// PARAMETERS
//  CLK_FREQ   50_000_000              clk cycles per second (prescaler terminal count + 1); >= 2
//  SEC_W      8                       width of a duration / secs_left, in seconds
//  NUM_SLOTS  4                       number of duration slots; >= 2
//  INIT_DURS  {8'd2,8'd4,8'd4,8'd25}  packed reset durations, slot i = INIT_DURS[i*SEC_W +: SEC_W]
//  SLOT_W     $clog2(NUM_SLOTS)       derived index width (localparam)
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  start      in   1       pulse: begin timing slot slot_sel (retriggers if busy)
//  slot_sel   in   SLOT_W  slot used when start=1
//  abort      in   1       pulse: stop timing, no done
//  pause      in   1       level: freeze countdown while high
//  load_we    in   1       write load_val into slot load_slot
//  load_slot  in   SLOT_W  slot written by load_we
//  load_val   in   SEC_W   new duration, seconds
//  busy       out  1       high in RUN or HOLD
//  done       out  1       one-cycle pulse at natural expiry
//  secs_left  out  SEC_W   whole seconds remaining (registered)
// BEHAVIOUR
//  Reset: state=IDLE, prescaler=0, busy=0, done=0, secs_left=0, slot[i]=INIT_DURS slice i.
//  States: IDLE, RUN, HOLD. busy is decoded from state (RUN|HOLD); done and secs_left are registers.
//  Priority per cycle: abort > start > countdown. done is 0 every cycle unless expiry or zero-start below.
//  abort (any state): next state IDLE, prescaler=0, secs_left=0, no done.
//  start, no abort, slot[slot_sel]==0: next IDLE, done=1 next cycle, secs_left=0 (zero-length phase).
//  start, no abort, dur!=0: secs_left=dur, prescaler=0, next = pause ? HOLD : RUN. Any run in progress is discarded, no done.
//  RUN, pause=1: next HOLD, prescaler held. HOLD, pause=0: next RUN. Prescaler and secs_left frozen in HOLD.
//  RUN, pause=0: prescaler increments; at CLK_FREQ-1 it wraps to 0 and secs_left decrements.
//  Expiry: decrement from 1->0 sets done=1 next cycle, state IDLE, busy=0 in the same cycle as done.
//  Latency: start sampled at edge E0, no pause -> done high the cycle after edge E0 + dur*CLK_FREQ; each paused cycle adds 1.
//  pause=1 in IDLE has no effect. start and pause together -> HOLD with secs_left=dur.
//  load_we writes the slot the next cycle; a running phase keeps its latched count. load_we and start on the same slot: start uses the OLD value.
//  Prescaler width $clog2(CLK_FREQ). No wrap below 0; secs_left is unsigned SEC_W.
//  rst mid-run: immediate return to reset values; loaded slots revert to INIT_DURS.
// TESTING (CLK_FREQ=10, SEC_W=8, NUM_SLOTS=4 for sim)
//  1 reset, start slot0 (25) -> secs_left 25..1 stepping every 10 cycles; done single pulse 250 cycles after start edge; busy low with done.
//  2 load slot2=3, start slot2; pause high 7 cycles during RUN -> done at 37 cycles; secs_left frozen while paused.
//  3 load slot1=0, start slot1 -> done 1 cycle later; busy never high.
//  4 start slot0; at cycle 100 start slot3 (2) -> no done for slot0; done 20 cycles after retrigger.
//  5 start slot0; abort at cycle 50 (also start same cycle) -> IDLE, secs_left=0, no done ever.
//  6 load slot0=5, run; assert rst mid-run -> all outputs 0 immediately; after release start slot0 -> 250-cycle run (INIT value).

Source files
------------

// File: rtl/phase_duration_timer.sv
// phase_duration_timer: multi-slot phase timer with pause, abort,
// retrigger, zero-length phases, a done pulse and a live seconds count.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start/slot_sel  begin timing slot slot_sel (retriggers if busy)
//   abort           stop timing, no done
//   pause           level; freezes the countdown while high
//   load_we/_slot   write load_val into duration slot load_slot
//   busy            high while a phase runs or is held
//   done            one-cycle pulse at natural expiry or zero-length start
//   secs_left       whole seconds remaining (registered)
module phase_duration_timer #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int SEC_W = 8,
    parameter int NUM_SLOTS = 4,
    parameter logic [NUM_SLOTS*SEC_W-1:0] INIT_DURS =
        {8'd2, 8'd4, 8'd4, 8'd25},
    localparam int SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SLOT_W-1:0] slot_sel,
    input  logic              abort,
    input  logic              pause,
    input  logic              load_we,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [SEC_W-1:0]  load_val,
    output logic              busy,
    output logic              done,
    output logic [SEC_W-1:0]  secs_left
);

    localparam int PW = $clog2(CLK_FREQ);
    localparam logic [PW-1:0] PRESC_TC = PW'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     presc, presc_nxt;
    logic [SEC_W-1:0]  secs_nxt;
    logic              done_nxt;
    logic [SEC_W-1:0]  sel_dur;
    logic [SEC_W-1:0]  slots [NUM_SLOTS];

    assign busy = (state == RUN) || (state == HOLD);

    // Read mux; an out-of-range index reads as a zero-length phase.
    always_comb begin
        sel_dur = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_sel == SLOT_W'(i)) begin
                sel_dur = slots[i];
            end
        end
    end

    // Slot writes land on the clock edge, so a start on the same
    // edge still sees the old duration through sel_dur.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slots[i] <= INIT_DURS[i*SEC_W +: SEC_W];
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (load_we && load_slot == SLOT_W'(i)) begin
                    slots[i] <= load_val;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            secs_left <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            presc     <= presc_nxt;
            secs_left <= secs_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        secs_nxt  = secs_left;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            secs_nxt  = '0;
        end else if (start) begin
            presc_nxt = '0;
            if (sel_dur == '0) begin
                state_nxt = IDLE;
                secs_nxt  = '0;
                done_nxt  = 1'b1;
            end else begin
                secs_nxt  = sel_dur;
                state_nxt = pause ? HOLD : RUN;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                // The edge that releases HOLD also counts, so every
                // paused cycle costs exactly one cycle of latency.
                RUN, HOLD: begin
                    if (pause) begin
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = RUN;
                        if (presc == PRESC_TC) begin
                            presc_nxt = '0;
                            if (secs_left <= SEC_W'(1)) begin
                                secs_nxt  = '0;
                                state_nxt = IDLE;
                                done_nxt  = (secs_left == SEC_W'(1));
                            end else begin
                                secs_nxt = secs_left - SEC_W'(1);
                            end
                        end else begin
                            presc_nxt = presc + PW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_duration_timer.sv
// tb_phase_duration_timer: directed scenarios plus random stimulus,
// checked every cycle against a tick-count reference model.
module tb_phase_duration_timer;

    localparam int F = 10;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] slot_sel;
    logic       abort;
    logic       pause;
    logic       load_we;
    logic [1:0] load_slot;
    logic [7:0] load_val;
    logic       busy;
    logic       done;
    logic [7:0] secs_left;

    int checks = 0;
    int failures = 0;

    phase_duration_timer #(
        .CLK_FREQ(F),
        .SEC_W(8),
        .NUM_SLOTS(4),
        .INIT_DURS({8'd2, 8'd4, 8'd4, 8'd25})
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .slot_sel(slot_sel),
        .abort(abort),
        .pause(pause),
        .load_we(load_we),
        .load_slot(load_slot),
        .load_val(load_val),
        .busy(busy),
        .done(done),
        .secs_left(secs_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Reference model: a phase is a number of counting cycles
    // (dur*F); seconds shown are that count rounded up to seconds.
    int m_rem;
    int m_act;
    int m_done;
    int m_secs;
    int m_d;
    int m_slot [4];

    task automatic m_reset();
        m_rem  = 0;
        m_act  = 0;
        m_done = 0;
        m_secs = 0;
        m_slot = '{25, 4, 4, 2};
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else begin
                m_d = m_slot[slot_sel];
                m_done = 0;
                if (abort) begin
                    m_act = 0;
                    m_rem = 0;
                end else if (start) begin
                    if (m_d == 0) begin
                        m_act  = 0;
                        m_rem  = 0;
                        m_done = 1;
                    end else begin
                        m_act = 1;
                        m_rem = m_d * F;
                    end
                end else if (m_act != 0 && !pause) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_act  = 0;
                        m_done = 1;
                    end
                end
                if (load_we) m_slot[load_slot] = int'(load_val);
            end
            m_secs = (m_rem + F - 1) / F;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("cyc_busy", int'(busy), m_act);
            chk("cyc_done", int'(done), m_done);
            chk("cyc_secs_left", int'(secs_left), m_secs);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int lim, output int k);
        k = 0;
        while (done !== 1'b1 && k < lim) begin
            tick();
            k++;
        end
    endtask

    task automatic load(input int s, input int v);
        load_we   = 1'b1;
        load_slot = 2'(s);
        load_val  = 8'(v);
        tick();
        load_we = 1'b0;
    endtask

    task automatic go(input int s);
        start    = 1'b1;
        slot_sel = 2'(s);
        tick();
        start = 1'b0;
    endtask

    int k;
    int dcnt;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        slot_sel = '0;
        abort = 1'b0;
        pause = 1'b0;
        load_we = 1'b0;
        load_slot = '0;
        load_val = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_secs", int'(secs_left), 0);
        rst = 1'b0;
        tick();

        // 1: slot0 = 25 s
        chk("model_slot0", m_slot[0], 25);
        go(0);
        chk("t1_secs_start", int'(secs_left), 25);
        chk("t1_model_secs", m_secs, 25);
        wait_done(400, k);
        chk("t1_latency", k, 250);
        chk("t1_busy_with_done", int'(busy), 0);
        tick();
        chk("t1_done_pulse", int'(done), 0);

        // 2: slot2 = 3 s with 7 paused cycles
        load(2, 3);
        go(2);
        k = 0;
        while (done !== 1'b1 && k < 100) begin
            pause = (k >= 5 && k < 12);
            tick();
            k++;
        end
        pause = 1'b0;
        chk("t2_latency", k, 37);
        tick();

        // 3: zero-length phase
        load(1, 0);
        go(1);
        chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 0);
        tick();
        chk("t3_done_pulse", int'(done), 0);

        // 4: retrigger slot3 (2 s) after 100 cycles
        go(0);
        dcnt = 0;
        repeat (100) begin
            tick();
            if (done) dcnt++;
        end
        go(3);
        wait_done(100, k);
        chk("t4_no_early_done", dcnt, 0);
        chk("t4_latency", k, 20);
        tick();

        // 5: abort with start in the same cycle
        go(0);
        repeat (49) tick();
        abort = 1'b1;
        start = 1'b1;
        slot_sel = 2'd0;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("t5_busy", int'(busy), 0);
        chk("t5_secs", int'(secs_left), 0);
        dcnt = 0;
        repeat (300) begin
            tick();
            if (done) dcnt++;
        end
        chk("t5_no_done", dcnt, 0);

        // 6: reset mid-run restores INIT durations
        load(0, 5);
        go(0);
        repeat (20) tick();
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_done", int'(done), 0);
        chk("t6_rst_secs", int'(secs_left), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        go(0);
        wait_done(400, k);
        chk("t6_latency", k, 250);
        tick();

        // Random traffic, short durations to see many expiries.
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 1499) == 0);
            start     = ($urandom_range(0, 39) == 0);
            slot_sel  = 2'($urandom_range(0, 3));
            abort     = ($urandom_range(0, 149) == 0);
            pause     = ($urandom_range(0, 3) == 0);
            load_we   = ($urandom_range(0, 19) == 0);
            load_slot = 2'($urandom_range(0, 3));
            load_val  = 8'($urandom_range(0, 5));
            tick();
        end
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        pause = 1'b0;
        load_we = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
